psram_sync_model: RTL and testbench

//  Synthesizable, parametrised PSRAM slave model for the SoC PSRAM port. Runs in the

---
 rtl/psram_sync_model.sv | 190 +++++++++++++++++++
 tb/tb_psram_sync_model.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_sync_model.sv
// psram_sync_model
//   Synthesizable PSRAM slave model. It runs in the system clock domain and
//   oversamples the host sck/ce_n lines. An internal byte array holds the
//   memory contents. The model supports SPI/QPI command entry, read wait
//   cycles, bursts with address auto-increment and wrap, QPI entry/exit and
//   a sticky error flag for unsupported commands.
// Ports
//   clock     in   1  system clock, at least 4x the sck frequency
//   reset     in   1  synchronous, active-high reset
//   sck       in   1  host serial clock, synchronous to clock
//   ce_n      in   1  host chip enable, active low
//   dio_i     in   4  data lines from the host
//   dio_o     out  4  data lines to the host, updated on sck falls
//   dio_oe    out  4  per-line output enable (the tristate is built at top level)
//   qpi_mode  out  1  1 = command phase uses 4 lines
//   busy      out  1  1 while the FSM is not idle
//   cmd_err   out  1  sticky flag: an unsupported command was seen
//   state_dbg out  3  current FSM state, for observation only
module psram_sync_model #(
  parameter int         MEM_AW    = 10,
  parameter int         READ_WAIT = 6,
  parameter logic [7:0] RCMD      = 8'hEB,
  parameter logic [7:0] WCMD      = 8'h38,
  parameter logic [7:0] QPI_EN    = 8'h35,
  parameter logic [7:0] QPI_EX    = 8'hF5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] dio_i,
  output logic [3:0] dio_o,
  output logic [3:0] dio_oe,
  output logic       qpi_mode,
  output logic       busy,
  output logic       cmd_err,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_WAIT  = 3'd3,
    S_RDATA = 3'd4,
    S_WDATA = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(READ_WAIT - 1);

  state_t              state;
  state_t              state_next;
  logic                sck_q;
  logic                rise;
  logic                fall;
  logic [7:0]          cnt;
  logic [7:0]          cmd;
  logic [7:0]          cmd_shift;
  logic                cmd_last;
  logic [MEM_AW-1:0]   idx;
  logic [MEM_AW-1:0]   idx_inc;
  logic [7:0]          rd_byte;
  logic [3:0]          wr_hi;
  logic                nib_lo;   // next read/write nibble is the low one
  logic                mem_we;
  logic [7:0]          mem [0:(1<<MEM_AW)-1];

  assign rise      = sck & ~sck_q;
  assign fall      = ~sck & sck_q;
  assign idx_inc   = idx + MEM_AW'(1);
  assign state_dbg = state;

  // Command byte as it will look after this rise; SPI takes one bit, QPI a nibble.
  assign cmd_shift = qpi_mode ? {cmd[3:0], dio_i} : {cmd[6:0], dio_i[0]};
  assign cmd_last  = rise && (cnt == (qpi_mode ? 8'd1 : 8'd7));
  assign mem_we    = !reset && !ce_n && (state == S_WDATA) && rise && nib_lo;

  always_ff @(posedge clock) begin
    sck_q <= sck;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; a high ce_n always returns to idle, even on an sck rise.
  always_comb begin
    state_next = state;
    if (ce_n) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_next = S_CMD;
        S_CMD: begin
          if (cmd_last) begin
            if (cmd_shift == RCMD || cmd_shift == WCMD)
              state_next = S_ADDR;
            else if (cmd_shift == QPI_EN || (cmd_shift == QPI_EX && qpi_mode))
              state_next = S_DONE;
            else
              state_next = S_ERR;
          end
        end
        S_ADDR:  if (rise && cnt == 8'd5) state_next = (cmd == RCMD) ? S_WAIT : S_WDATA;
        S_WAIT:  if (rise && cnt == WAIT_LAST) state_next = S_RDATA;
        default: state_next = state;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy   = (state != S_IDLE);
    dio_oe = ((state == S_WAIT || state == S_RDATA) && !ce_n) ? 4'hF : 4'h0;
  end

  // Datapath: counters, shift registers, read pipeline and mode flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      dio_o    <= 4'h0;
      qpi_mode <= 1'b0;
      cmd_err  <= 1'b0;
      cnt      <= 8'd0;
      cmd      <= 8'd0;
      idx      <= '0;
      rd_byte  <= 8'd0;
      wr_hi    <= 4'h0;
      nib_lo   <= 1'b0;
    end else begin
      // The counter restarts on every state change, so each phase counts from 0.
      if (state_next != state) cnt <= 8'd0;
      else if (rise)           cnt <= cnt + 8'd1;

      if (state == S_CMD && state_next == S_ERR) cmd_err <= 1'b1;
      // Mode changes land only when a completed mode command's frame closes.
      if (state == S_DONE && ce_n) qpi_mode <= (cmd == QPI_EN);

      case (state)
        S_IDLE: begin
          dio_o  <= 4'h0;
          nib_lo <= 1'b0;
        end
        S_CMD:  if (rise && !ce_n) cmd <= cmd_shift;
        S_ADDR: if (rise && !ce_n) idx <= {idx[MEM_AW-5:0], dio_i};
        S_WAIT: begin
          dio_o <= 4'h0;
          if (rise && !ce_n && cnt == WAIT_LAST) begin
            rd_byte <= mem[idx];
            nib_lo  <= 1'b0;
          end
        end
        S_RDATA: begin
          if (fall && !ce_n) begin
            if (!nib_lo) begin
              dio_o  <= rd_byte[7:4];
              nib_lo <= 1'b1;
            end else begin
              dio_o   <= rd_byte[3:0];
              nib_lo  <= 1'b0;
              idx     <= idx_inc;
              rd_byte <= mem[idx_inc];
            end
          end
        end
        S_WDATA: begin
          if (rise && !ce_n) begin
            if (!nib_lo) begin
              wr_hi  <= dio_i;
              nib_lo <= 1'b1;
            end else begin
              idx    <= idx_inc;
              nib_lo <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Array is deliberately never cleared by reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem[idx] <= {wr_hi, dio_i};
  end

endmodule

// File: tb/tb_psram_sync_model.sv
module tb_psram_sync_model;

  localparam int         AW     = 10;
  localparam int         DEPTH  = 1 << AW;
  localparam logic [7:0] RCMD   = 8'hEB;
  localparam logic [7:0] WCMD   = 8'h38;
  localparam logic [7:0] QPI_EN = 8'h35;
  localparam logic [7:0] QPI_EX = 8'hF5;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sck   = 1'b0;
  logic       ce_n  = 1'b1;
  logic [3:0] dio_i = 4'h0;

  logic [3:0] dio_o1, dio_oe1, dio_o2, dio_oe2;
  logic       qpi1, busy1, err1, qpi2, busy2, err2;
  logic [2:0] st1, st2;

  always #5 clock = ~clock;

  psram_sync_model #(.MEM_AW(AW), .READ_WAIT(6)) dut (
    .clock(clock), .reset(reset), .sck(sck), .ce_n(ce_n), .dio_i(dio_i),
    .dio_o(dio_o1), .dio_oe(dio_oe1), .qpi_mode(qpi1), .busy(busy1),
    .cmd_err(err1), .state_dbg(st1)
  );

  psram_sync_model #(.MEM_AW(AW), .READ_WAIT(2)) dut2 (
    .clock(clock), .reset(reset), .sck(sck), .ce_n(ce_n), .dio_i(dio_i),
    .dio_o(dio_o2), .dio_oe(dio_oe2), .qpi_mode(qpi2), .busy(busy2),
    .cmd_err(err2), .state_dbg(st2)
  );

  // ---------------- reference model / scoreboard ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] model_mem [DEPTH];
  bit         model_qpi = 1'b0;
  logic [7:0] wbuf [8];
  logic [3:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic sck_rise(input logic [3:0] d);
    dio_i = d;
    repeat (2) @(negedge clock);
    sck = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic sck_fall();
    sck = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic sck_pulse(input logic [3:0] d);
    sck_rise(d);
    sck_fall();
  endtask

  task automatic frame_start();
    ce_n = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic frame_end();
    ce_n = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic send_cmd(input logic [7:0] c, input bit q);
    if (q) begin
      sck_pulse(c[7:4]);
      sck_pulse(c[3:0]);
    end else begin
      for (int b = 7; b >= 0; b--) begin
        logic [3:0] d;
        d    = 4'($urandom_range(0, 15));  // upper lines are noise in SPI mode
        d[0] = c[b];
        sck_pulse(d);
      end
    end
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int n = 5; n >= 0; n--) sck_pulse(a[n*4 +: 4]);
  endtask

  task automatic write_frame(input logic [23:0] a, input int nbytes);
    frame_start();
    send_cmd(WCMD, model_qpi);
    send_addr(a);
    for (int i = 0; i < nbytes; i++) begin
      sck_pulse(wbuf[i][7:4]);
      sck_pulse(wbuf[i][3:0]);
      model_mem[(int'(a[AW-1:0]) + i) % DEPTH] = wbuf[i];
    end
    frame_end();
  endtask

  task automatic read_frame(input logic [23:0] a, input int nbytes, input int waitn,
                            input bit use2, input string tag);
    logic [7:0] b;
    for (int i = 0; i < nbytes; i++) begin
      b = model_mem[(int'(a[AW-1:0]) + i) % DEPTH];
      exp_q.push_back(b[7:4]);
      exp_q.push_back(b[3:0]);
    end
    frame_start();
    send_cmd(RCMD, model_qpi);
    check_eq({tag, "_oe_cmd"}, use2 ? dio_oe2 : dio_oe1, 4'h0);
    send_addr(a);
    for (int k = 1; k <= waitn; k++) begin
      sck_rise(4'($urandom_range(0, 15)));
      check_eq({tag, "_oe_wait"}, use2 ? dio_oe2 : dio_oe1, 4'hF);
      check_eq({tag, "_o_wait"}, use2 ? dio_o2 : dio_o1, 4'h0);
      sck_fall();
    end
    for (int j = 0; j < 2 * nbytes; j++) begin
      if (j > 0) sck_pulse(4'($urandom_range(0, 15)));
      check_eq({tag, "_nib"}, use2 ? dio_o2 : dio_o1, exp_q.pop_front());
      check_eq({tag, "_oe_rd"}, use2 ? dio_oe2 : dio_oe1, 4'hF);
    end
    frame_end();
    check_eq({tag, "_oe_end"}, use2 ? dio_oe2 : dio_oe1, 4'h0);
    check_eq({tag, "_busy_end"}, use2 ? busy2 : busy1, 1'b0);
  endtask

  task automatic mode_frame(input logic [7:0] c, input string tag);
    frame_start();
    send_cmd(c, model_qpi);
    check_eq({tag, "_busy"}, busy1, 1'b1);
    check_eq({tag, "_qpi_hold"}, qpi1, model_qpi);
    frame_end();
    model_qpi = (c == QPI_EN);
    check_eq({tag, "_qpi"}, qpi1, model_qpi);
    check_eq({tag, "_qpi2"}, qpi2, model_qpi);
  endtask

  task automatic err_frame(input logic [7:0] c, input string tag);
    frame_start();
    send_cmd(c, model_qpi);
    check_eq({tag, "_err"}, err1, 1'b1);
    check_eq({tag, "_oe"}, dio_oe1, 4'h0);
    check_eq({tag, "_busy"}, busy1, 1'b1);
    sck_pulse(4'hF);
    sck_pulse(4'h0);
    check_eq({tag, "_oe_more"}, dio_oe1, 4'h0);
    check_eq({tag, "_busy_more"}, busy1, 1'b1);
    frame_end();
    check_eq({tag, "_busy_end"}, busy1, 1'b0);
    check_eq({tag, "_err_sticky"}, err1, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clock);
    check_eq("rst_dio_o", dio_o1, 4'h0);
    check_eq("rst_dio_oe", dio_oe1, 4'h0);
    check_eq("rst_qpi", qpi1, 1'b0);
    check_eq("rst_busy", busy1, 1'b0);
    check_eq("rst_err", err1, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // SPI write then read back a two-byte burst
    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    write_frame(24'h000010, 2);
    read_frame(24'h000010, 2, 6, 1'b0, "t1");

    // QPI entry, 2-nibble read command, QPI exit
    mode_frame(QPI_EN, "t2_en");
    read_frame(24'h000010, 1, 6, 1'b0, "t2_rd");
    mode_frame(QPI_EX, "t2_ex");

    // Wrap at the top of the array
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    write_frame(24'h0003FF, 2);
    read_frame(24'h000000, 1, 6, 1'b0, "t3_lo");
    read_frame(24'h0003FF, 1, 6, 1'b0, "t3_hi");
    read_frame(24'h0003FF, 2, 6, 1'b0, "t3_wrap");

    // Unsupported commands: exit-QPI while in SPI, then an unknown opcode
    err_frame(QPI_EX, "t4_f5");
    read_frame(24'h000010, 2, 6, 1'b0, "t4_rd");
    err_frame(8'h9F, "t4_9f");
    read_frame(24'h000011, 1, 6, 1'b0, "t4_rd2");
    check_eq("t4_err_kept", err1, 1'b1);

    // Aborted write leaves the array untouched
    wbuf[0] = 8'h5A;
    write_frame(24'h000020, 1);
    frame_start();
    send_cmd(WCMD, model_qpi);
    send_addr(24'h000020);
    sck_pulse(4'h7);
    frame_end();
    read_frame(24'h000020, 1, 6, 1'b0, "t5_abort");

    // Reset in the middle of a read burst
    frame_start();
    send_cmd(RCMD, model_qpi);
    send_addr(24'h000010);
    for (int k = 0; k < 7; k++) sck_pulse(4'h0);
    check_eq("t5_in_rdata_oe", dio_oe1, 4'hF);
    reset = 1'b1;
    @(negedge clock);
    check_eq("t5_rst_oe", dio_oe1, 4'h0);
    check_eq("t5_rst_busy", busy1, 1'b0);
    ce_n = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_qpi = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("t5_err_cleared", err1, 1'b0);

    // Short-wait build: latency of two wait rises
    read_frame(24'h000010, 2, 2, 1'b1, "t6");

    // Randomized traffic against the model
    for (int it = 0; it < 20; it++) begin
      logic [23:0] a;
      int          n;
      if ($urandom_range(0, 2) == 0) mode_frame(model_qpi ? QPI_EX : QPI_EN, "rnd_mode");
      a = 24'($urandom);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom_range(0, 255));
      write_frame(a, n);
      if ($urandom_range(0, 1) == 0) read_frame(a, n, 6, 1'b0, "rnd_rd6");
      else                           read_frame(a, n, 2, 1'b1, "rnd_rd2");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
